elevator_scan_ctrl: RTL
=======================

// Module: elevator_scan_ctrl
// PURPOSE
//  Parametrised N-floor elevator controller; successor to the fixed 4-floor elevator FSM.
//  - Latches one-hot floor requests into a pending mask.
//  - Schedules them with SCAN: keep direction while work remains ahead, else reverse.
//  - Times floor travel and door dwell with internal tick counters.
//  - Drives motor and door outputs; reports current floor, direction and pending mask.
// PARAMETERS
//  NUM_FLOORS   4   number of floors, >=2; floor 0 is the lowest
//  FLOOR_TICKS  8   clk cycles to travel one floor, >=1
//  DOOR_TICKS   16  clk cycles the door stays open per stop, >=1
// PORTS
//  clk        in   1           single clock, rising edge
//  rst_n      in   1           asynchronous reset, active-low
//  floor_req  in   NUM_FLOORS  request pulses, any number of bits high, sampled every edge
//  move_up    out  1           motor up (registered)
//  move_down  out  1           motor down (registered); never high together with move_up
//  door_open  out  1           door open (registered); never high together with a move_* output
//  cur_floor  out  FW          current floor, FW=$clog2(NUM_FLOORS)
//  dir_up     out  1           SCAN direction: 1=up, 0=down
//  pending    out  NUM_FLOORS  latched, not-yet-served requests
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE; cur_floor=0; dir_up=1; pending=0; move_*=0; door_open=0; counters=0.
//  Request latch: pending <= (pending | floor_req) & ~serve_mask.
//  - serve_mask is the cur_floor bit when entering or staying in DOOR_OPEN.
//  - floor_req[cur_floor] in IDLE => enter DOOR_OPEN at next edge; bit is never left pending.
//  - floor_req[cur_floor] in DOOR_OPEN => dwell counter reloads (door held); bit not latched.
//  States and transitions:
//  - IDLE: cur-floor pending -> DOOR_OPEN.
//    Else work above and (dir_up or nothing below) -> MOVE_UP, dir_up=1.
//    Else work below -> MOVE_DOWN, dir_up=0.
//  - MOVE_UP/MOVE_DOWN: count FLOOR_TICKS cycles, then cur_floor +/-1.
//    Arrival floor pending -> DOOR_OPEN and clear its bit; else keep moving.
//  - DOOR_OPEN: count DOOR_TICKS cycles, then go to the next state by the IDLE rules
//    with direction preference kept, or to IDLE if nothing is pending.
//  Latency: request at edge k -> pending bit visible after edge k -> move_* high after edge k+1.
//  Bounds: never move above NUM_FLOORS-1 or below 0.
//    Reversal happens only in DOOR_OPEN/IDLE, never mid-floor.
//  Simultaneous events: a new request for the arrival floor in the arrival cycle is absorbed by
//    that stop; requests for other floors during motion are latched and served by SCAN order.
//  Reset mid-move or mid-dwell: immediate return to reset values; pending mask lost.
// CONFIGURATION
//  ELEV_ESTOP_EN defined: adds input estop (1 bit) and state ESTOP.
//  - estop=1 from any state -> ESTOP at next edge; move_*=0, door_open=0.
//  - pending is kept, requests are still latched, travel counter is frozen.
//  - estop=0 -> IDLE, re-evaluated by the IDLE rules from cur_floor.
//  ELEV_ESTOP_EN undefined: no estop port, no ESTOP state.
// STRUCTURE
//  elevator_defs.vh: state encodings (IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN, ESTOP) and
//    the FW width macro.
//  Sub-module elevator_tick_timer: loadable down-counter sized for max(FLOOR_TICKS, DOOR_TICKS),
//    with load/en inputs and a done pulse.
//  Top level holds the request latch, above/below reduction masks, FSM and output registers.
// TESTING  (NUM_FLOORS=4, FLOOR_TICKS=4, DOOR_TICKS=8)
//  1. rst_n=0 mid-MOVE_UP -> all outputs 0, cur_floor=0, dir_up=1, pending=0 within the same cycle.
//  2. floor_req=4'b0100 one cycle from IDLE@0 -> move_up 2 edges later.
//     cur_floor reaches 2 after 8 cycles; door_open for 8 cycles; pending=0; then IDLE.
//  3. At floor 2 moving up, requests 4'b1000 and 4'b0001 together ->
//     serve 3 first, reverse, then serve 0; move_up/move_down never both 1.
//  4. floor_req=4'b0001 while IDLE@0 -> door_open after 1 edge, pending stays 0.
//     Repeated req during dwell extends door_open.
//  5. Request for 3 while passing 1 upward toward 2 -> stops at 2, then 3; no reversal in between.
//  6. (ELEV_ESTOP_EN) estop pulse mid-travel -> outputs 0 next edge, pending kept;
//     on release the target is still reached.

Source files
------------

// File: rtl/elevator_scan_ctrl_pkg.sv
// Shared definitions for the SCAN elevator controller: FSM state encoding
// and small elaboration-time helpers for sizing the tick timer.
// ELEV_ESTOP_EN adds the emergency-stop state to the encoding.
package elevator_scan_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_MOVE_UP   = 3'd1,
    ST_MOVE_DOWN = 3'd2,
    ST_DOOR_OPEN = 3'd3
`ifdef ELEV_ESTOP_EN
    , ST_ESTOP   = 3'd4
`endif
  } elev_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to hold a countdown starting at max_ticks.
  function automatic int tick_width(input int max_ticks);
    return $clog2(max_ticks + 1);
  endfunction

endpackage

// File: rtl/elevator_tick_timer.sv
// Loadable down-counter shared by floor travel and door dwell timing.
// done flags the last tick of a countdown (count == 1); the owner acts on it
// only while it is enabling the counter, so the flag never feeds back into en.
module elevator_tick_timer #(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          en,
  input  logic [CW-1:0] load_val,
  output logic          done
);

  logic [CW-1:0] count_reg;

  // Load has priority; otherwise count down while enabled, saturating at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (en && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign done = (count_reg == CW'(1));

endmodule

// File: rtl/elevator_scan_ctrl.sv
// N-floor elevator controller with SCAN scheduling.
// Holds the pending-request latch, above/below reduction masks, the
// three-process FSM and the registered motor/door outputs.
// Optional feature: define ELEV_ESTOP_EN to add the estop input and ESTOP state.
module elevator_scan_ctrl
  import elevator_scan_ctrl_pkg::*;
#(
  parameter  int NUM_FLOORS  = 4,
  parameter  int FLOOR_TICKS = 8,
  parameter  int DOOR_TICKS  = 16,
  localparam int FW          = $clog2(NUM_FLOORS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef ELEV_ESTOP_EN
  input  logic                  estop,
`endif
  input  logic [NUM_FLOORS-1:0] floor_req,
  output logic                  move_up,
  output logic                  move_down,
  output logic                  door_open,
  output logic [FW-1:0]         cur_floor,
  output logic                  dir_up,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int              CW         = tick_width(max_int(FLOOR_TICKS, DOOR_TICKS));
  localparam logic [FW-1:0]   TOP_FLOOR  = FW'(NUM_FLOORS - 1);
  localparam logic [CW-1:0]   FLOOR_LOAD = CW'(FLOOR_TICKS);
  localparam logic [CW-1:0]   DOOR_LOAD  = CW'(DOOR_TICKS);

  elev_state_t           state_reg, state_next;
  logic [FW-1:0]         cur_floor_reg, floor_next;
  logic                  dir_up_reg, dir_next;
  logic [NUM_FLOORS-1:0] pending_reg, pending_next;
  logic                  move_up_reg, move_down_reg, door_open_reg;
  logic                  move_up_next, move_down_next, door_open_next;

  logic [NUM_FLOORS-1:0] req_eff, above_mask, below_mask;
  logic [NUM_FLOORS-1:0] cur_hot, up_hot, dn_hot, next_hot, serve_mask;
  logic                  work_above, work_below, go_up, go_down;
  logic                  req_here, req_up_floor, req_dn_floor;
  logic                  work_beyond_up, work_beyond_dn;
  logic                  tmr_load, tmr_en, tmr_done;
  logic [CW-1:0]         tmr_val;

  // Per-floor position masks relative to the current and next floor.
  for (genvar gi = 0; gi < NUM_FLOORS; gi = gi + 1) begin : g_masks
    assign above_mask[gi] = (gi > int'(cur_floor_reg));
    assign below_mask[gi] = (gi < int'(cur_floor_reg));
    assign cur_hot[gi]    = (gi == int'(cur_floor_reg));
    assign up_hot[gi]     = (gi == int'(cur_floor_reg) + 1);
    assign dn_hot[gi]     = (gi == int'(cur_floor_reg) - 1);
    assign next_hot[gi]   = (gi == int'(floor_next));
  end

  // Requests arriving this cycle count for stops at the current/arrival floor,
  // so such a request is absorbed by the stop rather than left pending.
  assign req_eff        = pending_reg | floor_req;
  assign work_above     = |(pending_reg & above_mask);
  assign work_below     = |(pending_reg & below_mask);
  assign go_up          = work_above && (dir_up_reg || !work_below);
  assign go_down        = work_below && !go_up;
  assign req_here       = |(req_eff & cur_hot);
  assign req_up_floor   = |(req_eff & up_hot);
  assign req_dn_floor   = |(req_eff & dn_hot);
  assign work_beyond_up = |(req_eff & above_mask & ~up_hot);
  assign work_beyond_dn = |(req_eff & below_mask & ~dn_hot);
  assign serve_mask     = (state_next == ST_DOOR_OPEN) ? next_hot : '0;
  assign pending_next   = req_eff & ~serve_mask;

  elevator_tick_timer #(.CW(CW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // State, position, direction and request-latch registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      cur_floor_reg <= '0;
      dir_up_reg    <= 1'b1;
      pending_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      cur_floor_reg <= floor_next;
      dir_up_reg    <= dir_next;
      pending_reg   <= pending_next;
    end
  end

  // Next-state logic: SCAN decisions, floor stepping and timer control.
  always_comb begin
    state_next = state_reg;
    floor_next = cur_floor_reg;
    dir_next   = dir_up_reg;
    tmr_load   = 1'b0;
    tmr_en     = 1'b0;
    tmr_val    = FLOOR_LOAD;
    case (state_reg)
      ST_IDLE: begin
        if (req_here) begin
          state_next = ST_DOOR_OPEN;
          tmr_load   = 1'b1;
          tmr_val    = DOOR_LOAD;
        end else if (go_up) begin
          state_next = ST_MOVE_UP;
          dir_next   = 1'b1;
          tmr_load   = 1'b1;
        end else if (go_down) begin
          state_next = ST_MOVE_DOWN;
          dir_next   = 1'b0;
          tmr_load   = 1'b1;
        end
      end
      ST_MOVE_UP: begin
        tmr_en = 1'b1;
        if (cur_floor_reg == TOP_FLOOR) begin
          state_next = ST_IDLE;
        end else if (tmr_done) begin
          floor_next = cur_floor_reg + 1'b1;
          if (req_up_floor) begin
            state_next = ST_DOOR_OPEN;
            tmr_load   = 1'b1;
            tmr_val    = DOOR_LOAD;
          end else if (work_beyond_up) begin
            tmr_load = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      ST_MOVE_DOWN: begin
        tmr_en = 1'b1;
        if (cur_floor_reg == '0) begin
          state_next = ST_IDLE;
        end else if (tmr_done) begin
          floor_next = cur_floor_reg - 1'b1;
          if (req_dn_floor) begin
            state_next = ST_DOOR_OPEN;
            tmr_load   = 1'b1;
            tmr_val    = DOOR_LOAD;
          end else if (work_beyond_dn) begin
            tmr_load = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      ST_DOOR_OPEN: begin
        if (req_here) begin
          // A fresh call at this floor holds the door for a full dwell.
          tmr_load = 1'b1;
          tmr_val  = DOOR_LOAD;
        end else begin
          tmr_en = 1'b1;
          if (tmr_done) begin
            if (go_up) begin
              state_next = ST_MOVE_UP;
              dir_next   = 1'b1;
              tmr_load   = 1'b1;
            end else if (go_down) begin
              state_next = ST_MOVE_DOWN;
              dir_next   = 1'b0;
              tmr_load   = 1'b1;
            end else begin
              state_next = ST_IDLE;
            end
          end
        end
      end
`ifdef ELEV_ESTOP_EN
      ST_ESTOP: begin
        state_next = ST_IDLE;
      end
`endif
      default: state_next = ST_IDLE;
    endcase
`ifdef ELEV_ESTOP_EN
    // Emergency stop overrides everything: position, direction and timer freeze.
    if (estop) begin
      state_next = ST_ESTOP;
      floor_next = cur_floor_reg;
      dir_next   = dir_up_reg;
      tmr_load   = 1'b0;
      tmr_en     = 1'b0;
    end
`endif
  end

  // Output decode from the next state so outputs change with the state register.
  always_comb begin
    move_up_next   = (state_next == ST_MOVE_UP);
    move_down_next = (state_next == ST_MOVE_DOWN);
    door_open_next = (state_next == ST_DOOR_OPEN);
  end

  // Registered motor and door outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      move_up_reg   <= 1'b0;
      move_down_reg <= 1'b0;
      door_open_reg <= 1'b0;
    end else begin
      move_up_reg   <= move_up_next;
      move_down_reg <= move_down_next;
      door_open_reg <= door_open_next;
    end
  end

  assign move_up   = move_up_reg;
  assign move_down = move_down_reg;
  assign door_open = door_open_reg;
  assign cur_floor = cur_floor_reg;
  assign dir_up    = dir_up_reg;
  assign pending   = pending_reg;

endmodule
